// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-road (NS/EW) intersection controller. The phases are green, yellow,
//   all-red clearance, a latched pedestrian walk and an emergency all-red
//   override. Every phase length is a parameter. The lamps and the phase
//   code decode from the state register only (Moore), so they add no latency.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   ped_req     pedestrian request, sampled each clk (a 1-cycle pulse is enough)
//   emer        emergency override level, sampled each clk
//   nsgreen/nsyellow/nsred   NS lamps (exactly one is lit)
//   ewgreen/ewyellow/ewred   EW lamps (exactly one is lit)
//   walk        pedestrian walk lamp
//   ped_pending request latched and not yet served
//   phase       current state code (0..7)
module traffic_light_ctrl #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       emer,
  output logic       nsgreen,
  output logic       nsyellow,
  output logic       nsred,
  output logic       ewgreen,
  output logic       ewyellow,
  output logic       ewred,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALLRED_NS = 3'd0,
    NS_G      = 3'd1,
    NS_Y      = 3'd2,
    ALLRED_EW = 3'd3,
    EW_G      = 3'd4,
    EW_Y      = 3'd5,
    WALK      = 3'd6,
    EMER      = 3'd7
  } state_t;

  // Terminal counts. A state exits on the edge where cnt == D-1.
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES  - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(WALK_CYCLES   - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ped_latch, ped_nxt;
  logic             enter_walk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ALLRED_NS;
      cnt       <= '0;
      ped_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ped_latch <= ped_nxt;
    end
  end

  // Next state. The emergency checks come before the normal timed exits.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ALLRED_NS: if (emer) state_nxt = EMER;
                 else if (cnt == AR_LAST) state_nxt = NS_G;
      // emer cuts the green short. The full yellow still runs.
      NS_G:      if (emer || cnt == G_LAST) state_nxt = NS_Y;
      // The yellow always finishes. emer then redirects it to EMER.
      NS_Y:      if (cnt == Y_LAST) state_nxt = emer ? EMER : ALLRED_EW;
      ALLRED_EW: if (emer) state_nxt = EMER;
                 else if (cnt == AR_LAST) state_nxt = EW_G;
      EW_G:      if (emer || cnt == G_LAST) state_nxt = EW_Y;
      EW_Y:      if (cnt == Y_LAST)
                   state_nxt = emer ? EMER : (ped_latch ? WALK : ALLRED_NS);
      WALK:      if (emer) state_nxt = EMER;
                 else if (cnt == W_LAST) state_nxt = ALLRED_NS;
      EMER:      if (!emer) state_nxt = ALLRED_NS;
      default:   state_nxt = ALLRED_NS;
    endcase
  end

  // The counter restarts on every state change. The saturation only matters
  // in EMER, because the timed states leave at D-1, which is <= CNT_MAX.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) cnt_nxt = '0;
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Entering WALK serves the latch. A request in that same cycle still sets
  // the latch, so that request is served on the next round.
  assign enter_walk = (state_nxt == WALK) && (state != WALK);

  always_comb begin
    ped_nxt = ped_latch;
    if (enter_walk) ped_nxt = 1'b0;
    if (ped_req)    ped_nxt = 1'b1;
  end

  assign nsgreen     = (state == NS_G);
  assign nsyellow    = (state == NS_Y);
  assign nsred       = !(nsgreen || nsyellow);
  assign ewgreen     = (state == EW_G);
  assign ewyellow    = (state == EW_Y);
  assign ewred       = !(ewgreen || ewyellow);
  assign walk        = (state == WALK);
  assign ped_pending = ped_latch;
  assign phase       = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT 1: default parameters
  logic rst_n, ped_req, emer;
  logic nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk, ped_pending;
  logic [2:0] phase;

  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .emer(emer),
    .nsgreen(nsgreen), .nsyellow(nsyellow), .nsred(nsred),
    .ewgreen(ewgreen), .ewyellow(ewyellow), .ewred(ewred),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  // DUT 2: short parameter set with a 2-bit counter
  logic rst2_n, ped2, emer2;
  logic g2n, y2n, r2n, g2e, y2e, r2e, walk2, pend2;
  logic [2:0] phase2;

  traffic_light_ctrl #(
    .GREEN_CYCLES(3), .YELLOW_CYCLES(1), .ALLRED_CYCLES(2),
    .WALK_CYCLES(2), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .ped_req(ped2), .emer(emer2),
    .nsgreen(g2n), .nsyellow(y2n), .nsred(r2n),
    .ewgreen(g2e), .ewyellow(y2e), .ewred(r2e),
    .walk(walk2), .ped_pending(pend2), .phase(phase2)
  );

  // Expected phase k cycles after the reset release (period 22).
  function automatic logic [2:0] exp_ph22(int k);
    int m = k % 22;
    if (m == 0)  return 3'd0;
    if (m <= 8)  return 3'd1;
    if (m <= 10) return 3'd2;
    if (m == 11) return 3'd3;
    if (m <= 19) return 3'd4;
    return 3'd5;
  endfunction

  // Same for the short set: 0(2) 1(3) 2(1) 3(2) 4(3) 5(1), period 12.
  function automatic logic [2:0] exp_ph12(int k);
    int m = k % 12;
    if (m <= 1)  return 3'd0;
    if (m <= 4)  return 3'd1;
    if (m == 5)  return 3'd2;
    if (m <= 7)  return 3'd3;
    if (m <= 10) return 3'd4;
    return 3'd5;
  endfunction

  // Inputs are driven and outputs sampled on the falling edge. After
  // do_reset returns, the current interval is cycle 0 (ALLRED_NS).
  task automatic do_reset();
    rst_n = 1'b0; ped_req = 1'b0; emer = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ped_req = 1'b1; emer = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({nsgreen,nsyellow,nsred,ewgreen,ewyellow,ewred,walk,ped_pending,phase} !== {8'b0010_0100, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ns=%b%b%b ew=%b%b%b walk=%b pend=%b phase=%0d, want ns=001 ew=001 walk=0 pend=0 phase=0",
               nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk, ped_pending, phase);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_normal();
    do_reset();
    for (int k = 0; k < 44; k++) begin
      logic [2:0] e;
      e = exp_ph22(k);
      n_cmp++;
      if (phase !== e) begin
        n_bad++; $display("FAIL normal_phase c%0d: got %0d want %0d", k, phase, e);
      end
      n_cmp++;
      if ({nsgreen,nsyellow,nsred,ewgreen,ewyellow,ewred,walk} !==
          {e==3'd1, e==3'd2, !(e==3'd1||e==3'd2), e==3'd4, e==3'd5, !(e==3'd4||e==3'd5), 1'b0}) begin
        n_bad++;
        $display("FAIL normal_lamps c%0d: got ns=%b%b%b ew=%b%b%b walk=%b for phase %0d",
                 k, nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ped();
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      logic [2:0] e;
      logic       ep, ew;
      e  = (k >= 22 && k <= 25) ? 3'd6 : (k == 26 ? 3'd0 : exp_ph22(k));
      ep = (k >= 4 && k <= 21);
      ew = (k >= 22 && k <= 25);
      n_cmp++;
      if (phase !== e) begin
        n_bad++; $display("FAIL ped_phase c%0d: got %0d want %0d", k, phase, e);
      end
      n_cmp++;
      if (ped_pending !== ep) begin
        n_bad++; $display("FAIL ped_pending c%0d: got %b want %b", k, ped_pending, ep);
      end
      n_cmp++;
      if (walk !== ew || (ew && (nsred !== 1'b1 || ewred !== 1'b1))) begin
        n_bad++; $display("FAIL ped_walk c%0d: got walk=%b nsred=%b ewred=%b want walk=%b", k, walk, nsred, ewred, ew);
      end
      ped_req = (k == 3);
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_emer();
    logic [2:0] exp_seq [12] = '{3'd0,3'd1,3'd1,3'd1,3'd2,3'd2,3'd7,3'd7,3'd7,3'd7,3'd0,3'd1};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (phase !== exp_seq[k]) begin
        n_bad++; $display("FAIL emer_phase c%0d: got %0d want %0d", k, phase, exp_seq[k]);
      end
      if (exp_seq[k] == 3'd7) begin
        n_cmp++;
        if ({nsred, ewred, walk} !== 3'b110) begin
          n_bad++; $display("FAIL emer_lamps c%0d: got nsred=%b ewred=%b walk=%b want 1 1 0", k, nsred, ewred, walk);
        end
      end
      if (k == 3) emer = 1'b1;
      if (k == 9) emer = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_ped_at_walk();
    do_reset();
    for (int k = 0; k <= 48; k++) begin
      if (k >= 22 && k <= 25) begin
        n_cmp++;
        if (phase !== 3'd6 || ped_pending !== 1'b1) begin
          n_bad++; $display("FAIL walk_reped c%0d: got phase=%0d pend=%b want 6 1", k, phase, ped_pending);
        end
      end
      if (k == 26 || k == 47) begin
        n_cmp++;
        if (phase !== (k == 26 ? 3'd0 : 3'd5)) begin
          n_bad++; $display("FAIL walk_round c%0d: got %0d want %0d", k, phase, (k == 26 ? 0 : 5));
        end
      end
      if (k == 48) begin
        n_cmp++;
        if (phase !== 3'd6 || walk !== 1'b1 || ped_pending !== 1'b0) begin
          n_bad++; $display("FAIL walk_second c48: got phase=%0d walk=%b pend=%b want 6 1 0", phase, walk, ped_pending);
        end
      end
      ped_req = (k == 2 || k == 21);
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      ped_req = (k == 2);
      @(negedge clk);
    end
    ped_req = 1'b0;
    n_cmp++;
    if (phase !== 3'd4 || ped_pending !== 1'b1) begin
      n_bad++; $display("FAIL arst_pre: got phase=%0d pend=%b want 4 1", phase, ped_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({nsgreen,nsyellow,nsred,ewgreen,ewyellow,ewred,walk,ped_pending,phase} !== {8'b0010_0100, 3'd0}) begin
      n_bad++;
      $display("FAIL arst_now: got ns=%b%b%b ew=%b%b%b walk=%b pend=%b phase=%0d want 001 001 0 0 0",
               nsgreen, nsyellow, nsred, ewgreen, ewyellow, ewred, walk, ped_pending, phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (phase !== exp_ph22(k) || ped_pending !== 1'b0) begin
        n_bad++; $display("FAIL arst_restart c%0d: got phase=%0d pend=%b want %0d 0", k, phase, ped_pending, exp_ph22(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_params();
    rst2_n = 1'b0; ped2 = 1'b0; emer2 = 1'b0;
    @(negedge clk); @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n_cmp++;
      if (phase2 !== exp_ph12(k)) begin
        n_bad++; $display("FAIL p2_phase c%0d: got %0d want %0d", k, phase2, exp_ph12(k));
      end
      @(negedge clk);
    end
    // cycle 24: start of a round, ALLRED_NS
    emer2 = 1'b1;
    for (int k = 25; k <= 34; k++) begin
      @(negedge clk);
      n_cmp++;
      if (phase2 !== 3'd7 || r2n !== 1'b1 || r2e !== 1'b1) begin
        n_bad++; $display("FAIL p2_emer c%0d: got phase=%0d nsred=%b ewred=%b want 7 1 1", k, phase2, r2n, r2e);
      end
    end
    n_cmp++;
    if (dut2.cnt !== 2'd3) begin
      n_bad++; $display("FAIL p2_sat: got cnt=%0d want 3", dut2.cnt);
    end
    emer2 = 1'b0;
    for (int k = 35; k <= 37; k++) begin
      @(negedge clk);
      n_cmp++;
      if (phase2 !== (k == 37 ? 3'd1 : 3'd0)) begin
        n_bad++; $display("FAIL p2_exit c%0d: got %0d want %0d", k, phase2, (k == 37 ? 1 : 0));
      end
    end
  endtask

  initial begin
    rst2_n = 1'b0; ped2 = 1'b0; emer2 = 1'b0;
    test_reset();
    test_normal();
    test_ped();
    test_emer();
    test_ped_at_walk();
    test_async_reset();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
